if_stage_hs: RTL and testbench
==============================

Name: if_stage_hs

Overview:
Handshaked instruction-fetch stage with an integrated IF/ID register. It sits directly upstream of the decode stage and replaces the fixed-latency fetch with one that tolerates a variable-latency instruction memory. It accepts decode stalls and branch redirects from the MEM stage (PCSrc, EX/MEM NPC). It presents IR, NPC and a valid flag to decode; invalid slots carry a NOP.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
INSTR_BYTES, 4, PC increment per instruction.
NOP_INSTR, 32'h0000_0000, IR value driven on reset, flush or empty slot.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
pcsrc  input  1  branch taken from MEM stage; redirect request.
branch_target  input  32  redirect PC (EX/MEM add result).
stall  input  1  decode cannot accept a new IF/ID entry this cycle.
imem_req  output  1  instruction memory request.
imem_addr  output  32  instruction memory byte address.
imem_ready  input  1  memory returns imem_rdata for the current request this cycle.
imem_rdata  input  32  instruction word.
if_id_ir  output  32  registered instruction to decode.
if_id_npc  output  32  registered PC+INSTR_BYTES of that instruction.
if_id_valid  output  1  IF/ID holds a real instruction.
pc  output  32  current fetch PC (debug/observability).

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC; if_id_ir=NOP_INSTR; if_id_npc=0; if_id_valid=0; skid buffer empty; state=IDLE; imem_req=0. Any outstanding memory transaction is abandoned. Memory must tolerate a dropped request.
- States: IDLE, FETCH, HOLD, DRAIN. imem_req=1 only in FETCH and DRAIN.
- IDLE: entered only from reset; moves to FETCH on the next edge unconditionally.
- FETCH: imem_addr=pc.
  - Transfer occurs when imem_req&&imem_ready in the same cycle.
  - imem_addr must stay stable while req=1 and ready=0.
- FETCH, ready=1, stall=0: if_id_ir<=imem_rdata; if_id_npc<=pc+INSTR_BYTES; if_id_valid<=1; pc<=pc+INSTR_BYTES; stay in FETCH (back-to-back requests).
- FETCH, ready=1, stall=1: capture rdata and npc into skid buffer; IF/ID unchanged; go to HOLD.
- HOLD: imem_req=0; IF/ID and pc hold. When stall=0: IF/ID<=skid contents, valid<=1, pc<=pc+INSTR_BYTES, go to FETCH.
- FETCH, ready=0, stall=1: IF/ID holds its content and valid flag.
- FETCH, ready=0, stall=0: IF/ID becomes a bubble (ir=NOP_INSTR, valid=0) so decode does not re-execute.
- Redirect (pcsrc=1) has highest priority over stall, in every state except IDLE:
  - pc<=branch_target.
  - IF/ID flushed: ir=NOP_INSTR, npc=0, valid=0.
  - Skid buffer emptied.
- Redirect in FETCH with ready=1, or in HOLD: the in-flight word is discarded; next state is FETCH, and the request to branch_target is issued next cycle.
- Redirect in FETCH with ready=0: go to DRAIN.
  - DRAIN keeps imem_req=1 with the old address until imem_ready, then discards the data.
  - Next state is FETCH at the stored target.
  - A second pcsrc during DRAIN overwrites the target.
- pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000. branch_target is used unaligned as given.
- Latency: with imem_ready tied 1 and stall=0, the first valid IF/ID appears at the edge 2 cycles after rst deasserts (IDLE, FETCH). Throughput is then 1 instruction/cycle.
- Synchronous reset mid-DRAIN or mid-HOLD returns to IDLE with no IF/ID update other than the reset values.

Test Plan:
- Reset, imem_ready=1, memory returns addr-based words: if_id_valid rises 2 cycles after rst falls; npc sequence 4,8,12…; ir matches mem[0],mem[4],…
- imem_ready pulses every 3rd cycle: imem_addr stable while waiting; IF/ID shows bubbles (valid=0, ir=0) between fetches; no instruction duplicated or skipped.
- stall=1 for 3 cycles arriving with ready=1 at pc=0x10: state HOLD; IF/ID keeps 0x0C entry; on release ir=mem[0x10], npc=0x14; next fetch addr 0x14.
- pcsrc=1, branch_target=0x100 while ready=1 at pc=0x20: IF/ID flushed to valid=0; next imem_addr=0x100; mem[0x20] never appears in IF/ID.
- pcsrc during an outstanding request (ready=0): imem_addr holds old address until ready; data dropped; next request addr=0x100. Also pcsrc with stall=1: flush wins and valid=0.
- RESET_PC=32'hFFFF_FFF8: PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. rst asserted mid-HOLD: all outputs return to reset values next edge.

Source files
------------

// File: rtl/if_stage_hs.sv
// ============================================================================
// Module      : if_stage_hs
// Description : Handshaked instruction-fetch stage with integrated IF/ID register
// Revision    : 1.0
// ============================================================================
`default_nettype none

module if_stage_hs #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned INSTR_BYTES = 4,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcsrc,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_ir,
    output logic [31:0] if_id_npc,
    output logic        if_id_valid,
    output logic [31:0] pc
);

    localparam logic [1:0]  c_S_IDLE  = 2'd0;
    localparam logic [1:0]  c_S_FETCH = 2'd1;
    localparam logic [1:0]  c_S_HOLD  = 2'd2;
    localparam logic [1:0]  c_S_DRAIN = 2'd3;
    localparam logic [31:0] c_INC     = 32'(INSTR_BYTES);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_npc;
    logic        r_valid;
    logic [31:0] r_skid_ir;
    logic [31:0] r_skid_npc;
    logic [31:0] r_drain_addr;
    logic [31:0] w_pc_inc;

    assign w_pc_inc = r_pc + c_INC;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a redirect outranks a decode stall
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: w_next_state = c_S_FETCH;
            c_S_FETCH: begin
                if (pcsrc) begin
                    w_next_state = imem_ready ? c_S_FETCH : c_S_DRAIN;
                end else if (imem_ready && stall) begin
                    w_next_state = c_S_HOLD;
                end
            end
            c_S_HOLD: begin
                if (pcsrc || !stall) begin
                    w_next_state = c_S_FETCH;
                end
            end
            c_S_DRAIN: begin
                if (imem_ready) begin
                    w_next_state = c_S_FETCH;
                end
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    // Outputs; DRAIN keeps presenting the abandoned address until memory answers
    always_comb begin
        imem_req  = (r_state == c_S_FETCH) || (r_state == c_S_DRAIN);
        imem_addr = (r_state == c_S_DRAIN) ? r_drain_addr : r_pc;
    end

    // Datapath: PC, IF/ID register and skid buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_ir         <= NOP_INSTR;
            r_npc        <= 32'h0000_0000;
            r_valid      <= 1'b0;
            r_skid_ir    <= NOP_INSTR;
            r_skid_npc   <= 32'h0000_0000;
            r_drain_addr <= 32'h0000_0000;
        end else if (r_state != c_S_IDLE) begin
            if (pcsrc) begin
                r_pc    <= branch_target;
                r_ir    <= NOP_INSTR;
                r_npc   <= 32'h0000_0000;
                r_valid <= 1'b0;
                if (r_state == c_S_FETCH) begin
                    r_drain_addr <= r_pc;
                end
            end else begin
                case (r_state)
                    c_S_FETCH: begin
                        if (imem_ready) begin
                            if (stall) begin
                                r_skid_ir  <= imem_rdata;
                                r_skid_npc <= w_pc_inc;
                            end else begin
                                r_ir    <= imem_rdata;
                                r_npc   <= w_pc_inc;
                                r_valid <= 1'b1;
                                r_pc    <= w_pc_inc;
                            end
                        end else if (!stall) begin
                            // Bubble so decode never re-executes the previous word
                            r_ir    <= NOP_INSTR;
                            r_valid <= 1'b0;
                        end
                    end
                    c_S_HOLD: begin
                        if (!stall) begin
                            r_ir    <= r_skid_ir;
                            r_npc   <= r_skid_npc;
                            r_valid <= 1'b1;
                            r_pc    <= w_pc_inc;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign if_id_ir    = r_ir;
    assign if_id_npc   = r_npc;
    assign if_id_valid = r_valid;
    assign pc          = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_if_stage_hs.sv
// ============================================================================
// Module      : tb_if_stage_hs
// Description : Scoreboard bench for if_stage_hs with an address-derived memory
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_npc;
    logic        if_id_valid;
    logic [31:0] pc;

    // Second instance exercises PC wrap-around from a high reset vector
    logic        w_zero = 1'b0;
    logic [31:0] w_zero32 = 32'h0;
    logic        w_one = 1'b1;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_rdata;
    logic [31:0] wr_ir;
    logic [31:0] wr_npc;
    logic        wr_valid;
    logic [31:0] wr_pc;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    if_stage_hs u_dut (
        .clk(clk), .rst(rst), .pcsrc(pcsrc), .branch_target(branch_target),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_id_ir(if_id_ir),
        .if_id_npc(if_id_npc), .if_id_valid(if_id_valid), .pc(pc)
    );

    if_stage_hs #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst(rst), .pcsrc(w_zero), .branch_target(w_zero32),
        .stall(w_zero), .imem_req(wr_req), .imem_addr(wr_addr),
        .imem_ready(w_one), .imem_rdata(wr_rdata), .if_id_ir(wr_ir),
        .if_id_npc(wr_npc), .if_id_valid(wr_valid), .pc(wr_pc)
    );

    always #5 clk = ~clk;

    // Memory returns a word derived from its address
    always_comb begin
        imem_rdata = {16'hE000, imem_addr[15:0]};
        wr_rdata   = {16'hE000, wr_addr[15:0]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Decode consumes the IF/ID entry on any cycle it is valid and not stalled
    always @(negedge clk) begin
        if (!rst && if_id_valid && !stall) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got ir=%h npc=%h expected none", if_id_ir, if_id_npc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({if_id_ir, if_id_npc} !== mon_e) begin
                    n_fail++;
                    $display("FAIL sb_entry: got ir=%h npc=%h expected ir=%h npc=%h",
                             if_id_ir, if_id_npc, mon_e[63:32], mon_e[31:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; pcsrc = 1'b0; branch_target = 32'h0; stall = 1'b0; imem_ready = 1'b1;
        tick(); tick();
        chk("reset_pc", pc, 32'h0);
        chk("reset_ir", if_id_ir, 32'h0);
        chk("reset_npc", if_id_npc, 32'h0);
        chk("reset_valid", 32'(if_id_valid), 32'h0);
        chk("reset_req", 32'(imem_req), 32'h0);
        chk("wrap_reset_pc", wr_pc, 32'hFFFF_FFF8);

        // Streaming fetch, then a stall that lands on the 0x10 fetch
        exp_q.push_back({32'hE000_0000, 32'h04});
        exp_q.push_back({32'hE000_0004, 32'h08});
        exp_q.push_back({32'hE000_0008, 32'h0C});
        exp_q.push_back({32'hE000_000C, 32'h10});
        exp_q.push_back({32'hE000_0010, 32'h14});
        rst = 1'b0;
        tick();
        chk("lat_valid_e1", 32'(if_id_valid), 32'h0);
        chk("lat_req_e1", 32'(imem_req), 32'h1);
        chk("lat_addr_e1", imem_addr, 32'h0);
        chk("wrap_addr_e1", wr_addr, 32'hFFFF_FFF8);
        tick();
        chk("lat_valid_e2", 32'(if_id_valid), 32'h1);
        chk("lat_npc_e2", if_id_npc, 32'h4);
        chk("wrap_npc_e2", wr_npc, 32'hFFFF_FFFC);
        chk("wrap_addr_e2", wr_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_npc_e3", wr_npc, 32'h0);
        chk("wrap_addr_e3", wr_addr, 32'h0);
        tick(); tick();
        chk("pre_stall_pc", pc, 32'h10);
        stall = 1'b1;
        tick();
        chk("hold_req", 32'(imem_req), 32'h0);
        chk("hold_npc", if_id_npc, 32'h10);
        chk("hold_ir", if_id_ir, 32'hE000_000C);
        chk("hold_valid", 32'(if_id_valid), 32'h1);
        tick(); tick();
        chk("hold_pc", pc, 32'h10);
        stall = 1'b0;
        tick();
        chk("release_ir", if_id_ir, 32'hE000_0010);
        chk("release_npc", if_id_npc, 32'h14);
        chk("release_addr", imem_addr, 32'h14);

        // Memory answers every third cycle
        exp_q.push_back({32'hE000_0014, 32'h18});
        exp_q.push_back({32'hE000_0018, 32'h1C});
        exp_q.push_back({32'hE000_001C, 32'h20});
        for (int k = 0; k < 3; k++) begin
            imem_ready = 1'b0;
            tick();
            chk("wait_valid", 32'(if_id_valid), 32'h0);
            chk("wait_ir", if_id_ir, 32'h0);
            chk("wait_addr_a", imem_addr, 32'h14 + 32'(4 * k));
            tick();
            chk("wait_addr_b", imem_addr, 32'h14 + 32'(4 * k));
            imem_ready = 1'b1;
            tick();
        end
        chk("slow_pc", pc, 32'h20);

        // Redirect while the 0x20 word is returning
        pcsrc = 1'b1; branch_target = 32'h100;
        tick();
        chk("flush_valid", 32'(if_id_valid), 32'h0);
        chk("flush_npc", if_id_npc, 32'h0);
        chk("flush_ir", if_id_ir, 32'h0);
        chk("flush_addr", imem_addr, 32'h100);
        pcsrc = 1'b0;
        tick();
        chk("target_npc", if_id_npc, 32'h104);

        // Redirect with an outstanding request and decode stalled
        stall = 1'b1; imem_ready = 1'b0;
        tick();
        chk("stall_wait_valid", 32'(if_id_valid), 32'h1);
        pcsrc = 1'b1; branch_target = 32'h200;
        tick();
        chk("drain_valid", 32'(if_id_valid), 32'h0);
        chk("drain_req", 32'(imem_req), 32'h1);
        chk("drain_addr", imem_addr, 32'h104);
        chk("drain_pc", pc, 32'h200);
        pcsrc = 1'b0; stall = 1'b0;
        tick();
        chk("drain_addr_hold", imem_addr, 32'h104);
        pcsrc = 1'b1; branch_target = 32'h300;
        tick();
        chk("drain_retarget_pc", pc, 32'h300);
        chk("drain_retarget_addr", imem_addr, 32'h104);
        pcsrc = 1'b0; imem_ready = 1'b1;
        tick();
        chk("drain_done_valid", 32'(if_id_valid), 32'h0);
        chk("drain_done_addr", imem_addr, 32'h300);
        exp_q.push_back({32'hE000_0300, 32'h304});
        tick(); tick();

        // Reset while holding a skid entry
        stall = 1'b1;
        tick();
        chk("hold2_req", 32'(imem_req), 32'h0);
        rst = 1'b1;
        tick();
        chk("rst_hold_pc", pc, 32'h0);
        chk("rst_hold_ir", if_id_ir, 32'h0);
        chk("rst_hold_npc", if_id_npc, 32'h0);
        chk("rst_hold_valid", 32'(if_id_valid), 32'h0);
        chk("rst_hold_req", 32'(imem_req), 32'h0);
        chk("wrap_rst_pc", wr_pc, 32'hFFFF_FFF8);

        rst = 1'b0; stall = 1'b0;
        exp_q.push_back({32'hE000_0000, 32'h04});
        tick(); tick();
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
